// File: rtl/coproc_pkg.sv
// Shared encodings for the Sobel coprocessor command front-end.
package coproc_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int MAT_W  = ELEM_W * N_ELEM;

    // Command word field positions
    localparam int CMD_LSB   = 0;
    localparam int MSEL_LSB  = 3;
    localparam int INDEX_LSB = 5;
    localparam int VALUE_LSB = 10;
    localparam int OPC_LSB   = 18;
    localparam int SIZE_LSB  = 21;
    localparam int FIELD_MSB = 22;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_SIZE  = 3'b010;
    localparam logic [2:0] CMD_RUN   = 3'b011;
    localparam logic [2:0] CMD_CLEAR = 3'b100;

    localparam logic [2:0] OP_SOBEL = 3'b111;

    typedef enum logic [1:0] {
        MSEL_A   = 2'b00,
        MSEL_B   = 2'b01,
        MSEL_C   = 2'b10,
        MSEL_BAD = 2'b11
    } msel_e;

    typedef enum logic [1:0] {
        SIZE_2X2 = 2'b00,
        SIZE_3X3 = 2'b01,
        SIZE_4X4 = 2'b10,
        SIZE_5X5 = 2'b11
    } size_e;

    typedef struct packed {
        size_e      size;
        logic [2:0] opcode;
        logic [7:0] value;
        logic [4:0] index;
        msel_e      msel;
        logic [2:0] cmd;
    } cmd_fields_t;

    // Splits the meaningful low part of a command word into its fields.
    function automatic cmd_fields_t decode_cmd(input logic [FIELD_MSB:0] word);
        cmd_fields_t f;
        f.cmd    = word[CMD_LSB +: 3];
        f.msel   = msel_e'(word[MSEL_LSB +: 2]);
        f.index  = word[INDEX_LSB +: 5];
        f.value  = word[VALUE_LSB +: 8];
        f.opcode = word[OPC_LSB +: 3];
        f.size   = size_e'(word[SIZE_LSB +: 2]);
        return f;
    endfunction

endpackage

// File: rtl/coproc_matrix_bank.sv
// Holds matrices A, B and C; element writes with range check, and a bulk clear.
module coproc_matrix_bank
    import coproc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  msel_e            msel_i,
    input  logic [4:0]       index_i,
    input  logic [7:0]       value_i,
    output logic             addr_err_o,
    output logic [MAT_W-1:0] mat_a_o,
    output logic [MAT_W-1:0] mat_b_o,
    output logic [MAT_W-1:0] mat_c_o
);

    logic [MAT_W-1:0] mat_a_q, mat_a_d;
    logic [MAT_W-1:0] mat_b_q, mat_b_d;
    logic [MAT_W-1:0] mat_c_q, mat_c_d;

    assign addr_err_o = (index_i > 5'(N_ELEM - 1)) || (msel_i == MSEL_BAD);

    // Next matrix contents: clear wins, out-of-range loads are dropped.
    always_comb begin
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        mat_c_d = mat_c_q;
        if (clear_i) begin
            mat_a_d = '0;
            mat_b_d = '0;
            mat_c_d = '0;
        end else if (load_i && !addr_err_o) begin
            case (msel_i)
                MSEL_A:  mat_a_d[int'(index_i) * ELEM_W +: ELEM_W] = value_i;
                MSEL_B:  mat_b_d[int'(index_i) * ELEM_W +: ELEM_W] = value_i;
                MSEL_C:  mat_c_d[int'(index_i) * ELEM_W +: ELEM_W] = value_i;
                default: ;
            endcase
        end
    end

    // Matrix registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
            mat_c_q <= '0;
        end else begin
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            mat_c_q <= mat_c_d;
        end
    end

    assign mat_a_o = mat_a_q;
    assign mat_b_o = mat_b_q;
    assign mat_c_o = mat_c_q;

endmodule

// File: rtl/coproc_cmd_sequencer.sv
// Command front-end: assembles operand matrices, runs the coprocessor and
// returns its result byte over a valid/ready response channel.
//
// state  | meaning
// IDLE   | accepting command words
// SETTLE | op_code held, coprocessor logic settling
// WAIT   | polling process_Done until timeout
// RESP   | response held until rsp_ready
module coproc_cmd_sequencer
    import coproc_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_error,
    output logic [2:0]       op_code,
    output logic [1:0]       matrix_size,
    output logic [MAT_W-1:0] matrix_a,
    output logic [MAT_W-1:0] matrix_b,
    output logic [MAT_W-1:0] matrix_c,
    input  logic             process_Done,
    input  logic [MAT_W-1:0] result_final
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_code_q, op_code_d;
    size_e            size_q, size_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;

    cmd_fields_t      cmd_f;
    logic             bank_load;
    logic             bank_clear;
    logic             bank_addr_err;

    // Upper command bits and upper result bits carry nothing for this block.
    logic             unused_bits;
    assign unused_bits = ^{cmd_data[31:FIELD_MSB+1], result_final[MAT_W-1:ELEM_W]};

    assign cmd_f = decode_cmd(cmd_data[FIELD_MSB:0]);

    coproc_matrix_bank u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (bank_load),
        .clear_i    (bank_clear),
        .msel_i     (cmd_f.msel),
        .index_i    (cmd_f.index),
        .value_i    (cmd_f.value),
        .addr_err_o (bank_addr_err),
        .mat_a_o    (matrix_a),
        .mat_b_o    (matrix_b),
        .mat_c_o    (matrix_c)
    );

    // Next-state, counter and response decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_code_d   = op_code_q;
        size_d      = size_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        bank_load   = 1'b0;
        bank_clear  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_f.cmd)
                        CMD_NOP: ;
                        CMD_LOAD: begin
                            bank_load = 1'b1;
                            if (bank_addr_err) begin
                                rsp_data_d  = 8'h00;
                                rsp_error_d = 1'b1;
                                state_d     = ST_RESP;
                            end
                        end
                        CMD_SIZE:  size_d = cmd_f.size;
                        CMD_CLEAR: bank_clear = 1'b1;
                        CMD_RUN: begin
                            op_code_d = cmd_f.opcode;
                            cnt_d     = SETTLE_LOAD;
                            state_d   = ST_SETTLE;
                        end
                        default: begin
                            rsp_data_d  = 8'h00;
                            rsp_error_d = 1'b1;
                            state_d     = ST_RESP;
                        end
                    endcase
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (process_Done) begin
                    rsp_data_d  = result_final[ELEM_W-1:0];
                    rsp_error_d = 1'b0;
                    op_code_d   = 3'b000;
                    state_d     = ST_RESP;
                end else if (cnt_q == '0) begin
                    rsp_data_d  = 8'h00;
                    rsp_error_d = 1'b1;
                    op_code_d   = 3'b000;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_code_q   <= 3'b000;
            size_q      <= SIZE_2X2;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_code_q   <= op_code_d;
            size_q      <= size_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign op_code     = op_code_q;
    assign matrix_size = size_q;

endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// Scoreboard bench for the coprocessor command sequencer.
module tb_coproc_cmd_sequencer;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;
    localparam int MW      = 200;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_data;
    logic          rsp_error;
    logic [2:0]    op_code;
    logic [1:0]    matrix_size;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic [MW-1:0] matrix_c;
    logic          process_Done;
    logic [MW-1:0] result_final;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [MW-1:0] model_a, model_b, model_c;
    logic [1:0]    model_size;
    int            n_checks;
    int            n_pass;

    coproc_cmd_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .op_code      (op_code),
        .matrix_size  (matrix_size),
        .matrix_a     (matrix_a),
        .matrix_b     (matrix_b),
        .matrix_c     (matrix_c),
        .process_Done (process_Done),
        .result_final (result_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_cmd(input logic [2:0] c, input logic [1:0] m,
                                           input logic [4:0] idx, input logic [7:0] v,
                                           input logic [2:0] opc, input logic [1:0] sz);
        return {9'd0, sz, opc, v, idx, m, c};
    endfunction

    task automatic send_cmd(input logic [31:0] w);
        @(negedge clk);
        cmd_data  = w;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    function automatic rsp_t pop_exp();
        rsp_t e;
        e = '{data: 8'hEE, err: 1'bx};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_error, op_code, matrix_size} !== 15'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {rsp_valid, rsp_data, rsp_error, op_code, matrix_size});
        else n_pass++;
        n_checks++;
        if ({matrix_a, matrix_b, matrix_c} !== '0)
            $display("FAIL reset_matrices: got nonzero expected 0");
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        else n_pass++;
        rst_n = 1'b1;
        model_a = '0; model_b = '0; model_c = '0; model_size = 2'b00;
    endtask

    task automatic test_load();
        send_cmd(mk_cmd(3'b001, 2'b00, 5'd24, 8'hAB, 3'b000, 2'b00));
        model_a[199:192] = 8'hAB;
        n_checks++;
        if (matrix_a !== model_a) $display("FAIL load_a24: got %h expected %h", matrix_a[199:184], model_a[199:184]);
        else n_pass++;
        send_cmd(mk_cmd(3'b001, 2'b01, 5'd0, 8'h01, 3'b000, 2'b00));
        model_b[7:0] = 8'h01;
        send_cmd(mk_cmd(3'b001, 2'b10, 5'd12, 8'h5C, 3'b000, 2'b00));
        model_c[103:96] = 8'h5C;
        n_checks++;
        if ({matrix_a, matrix_b, matrix_c} !== {model_a, model_b, model_c})
            $display("FAIL load_b0_c12: got b=%h c=%h expected b=%h c=%h",
                     matrix_b[7:0], matrix_c[103:96], model_b[7:0], model_c[103:96]);
        else n_pass++;
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL load_no_rsp: got ready/valid %b expected 10", {cmd_ready, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_load_errors();
        logic [31:0] bad [2];
        bit          seen;
        rsp_t        e;
        bad[0] = mk_cmd(3'b001, 2'b00, 5'd25, 8'hFF, 3'b000, 2'b00);
        bad[1] = mk_cmd(3'b001, 2'b11, 5'd3,  8'h77, 3'b000, 2'b00);
        for (int i = 0; i < 2; i++) begin
            send_cmd(bad[i]);
            exp_q.push_back('{data: 8'h00, err: 1'b1});
            wait_rsp(seen);
            e = pop_exp();
            n_checks++;
            if (!seen) $display("FAIL load_err_rsp%0d: got no response expected one", i);
            else n_pass++;
            n_checks++;
            if ({rsp_data, rsp_error} !== {e.data, e.err})
                $display("FAIL load_err_val%0d: got %h/%b expected %h/%b", i, rsp_data, rsp_error, e.data, e.err);
            else n_pass++;
            ack_rsp();
            n_checks++;
            if ({matrix_a, matrix_b, matrix_c} !== {model_a, model_b, model_c})
                $display("FAIL load_err_nowrite%0d: got matrix change expected none", i);
            else n_pass++;
        end
    endtask

    // RUN with a done stub on a given WAIT cycle; checks latency, op_code hold and result.
    task automatic run_with_done(input logic [2:0] opc, input int done_wait, input logic [7:0] res,
                                 input string tag);
        int   rise;
        int   op_bad;
        rsp_t e;
        rise   = 0;
        op_bad = 0;
        result_final = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), res};
        send_cmd(mk_cmd(3'b011, 2'b00, 5'd0, 8'h00, opc, 2'b00));
        exp_q.push_back('{data: res, err: 1'b0});
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            process_Done = (cyc == SETTLE + done_wait);
            if (rsp_valid === 1'b1) begin
                rise = cyc;
                break;
            end
            if (op_code !== opc) op_bad++;
        end
        process_Done = 1'b0;
        n_checks++;
        if (rise != SETTLE + done_wait + 1)
            $display("FAIL %s_latency: got %0d expected %0d", tag, rise, SETTLE + done_wait + 1);
        else n_pass++;
        n_checks++;
        if (op_bad != 0) $display("FAIL %s_op_hold: got %0d bad cycles expected 0", tag, op_bad);
        else n_pass++;
        n_checks++;
        if (op_code !== 3'b000) $display("FAIL %s_op_clear: got %b expected 000", tag, op_code);
        else n_pass++;
        e = pop_exp();
        n_checks++;
        if ({rsp_data, rsp_error} !== {e.data, e.err})
            $display("FAIL %s_result: got %h/%b expected %h/%b", tag, rsp_data, rsp_error, e.data, e.err);
        else n_pass++;
        ack_rsp();
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL %s_idle: got ready/valid %b expected 10", tag, {cmd_ready, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_run_sobel();
        send_cmd(mk_cmd(3'b010, 2'b00, 5'd0, 8'h00, 3'b000, 2'b01));
        model_size = 2'b01;
        n_checks++;
        if (matrix_size !== model_size) $display("FAIL size_set: got %b expected %b", matrix_size, model_size);
        else n_pass++;
        run_with_done(3'b111, 3, 8'h2A, "sobel");
    endtask

    task automatic test_back_to_back();
        bit   seen;
        rsp_t e;
        run_with_done(3'b111, 1, 8'h5D, "b2b_run");
        send_cmd(mk_cmd(3'b110, 2'b00, 5'd0, 8'h00, 3'b000, 2'b00));
        exp_q.push_back('{data: 8'h00, err: 1'b1});
        wait_rsp(seen);
        e = pop_exp();
        n_checks++;
        if (!seen || {rsp_data, rsp_error} !== {e.data, e.err})
            $display("FAIL illegal_cmd: got %b %h/%b expected 1 %h/%b", seen, rsp_data, rsp_error, e.data, e.err);
        else n_pass++;
        ack_rsp();
        send_cmd(mk_cmd(3'b001, 2'b00, 5'd7, 8'h33, 3'b000, 2'b00));
        model_a[63:56] = 8'h33;
        send_cmd(mk_cmd(3'b000, 2'b01, 5'd7, 8'h99, 3'b000, 2'b11));
        @(negedge clk);
        n_checks++;
        if ({matrix_a, matrix_b, matrix_c, matrix_size, rsp_valid} !==
            {model_a, model_b, model_c, model_size, 1'b0})
            $display("FAIL load_then_nop: got a7=%h size=%b valid=%b expected a7=%h size=%b valid=0",
                     matrix_a[63:56], matrix_size, rsp_valid, model_a[63:56], model_size);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int         rise;
        int         unstable;
        logic [8:0] held;
        rsp_t       e;
        rise = 0;
        unstable = 0;
        send_cmd(mk_cmd(3'b011, 2'b00, 5'd0, 8'h00, 3'b000, 2'b00));
        exp_q.push_back('{data: 8'h00, err: 1'b1});
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                rise = cyc;
                break;
            end
        end
        n_checks++;
        if (rise != SETTLE + TIMEOUT + 1)
            $display("FAIL timeout_latency: got %0d expected %0d", rise, SETTLE + TIMEOUT + 1);
        else n_pass++;
        n_checks++;
        if (op_code !== 3'b000) $display("FAIL timeout_op_clear: got %b expected 000", op_code);
        else n_pass++;
        held = {rsp_data, rsp_error};
        cmd_data  = mk_cmd(3'b010, 2'b00, 5'd0, 8'h00, 3'b000, 2'b11);
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({rsp_valid, cmd_ready, rsp_data, rsp_error} !== {1'b1, 1'b0, held}) unstable++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (unstable != 0) $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", unstable);
        else n_pass++;
        e = pop_exp();
        n_checks++;
        if ({rsp_data, rsp_error} !== {e.data, e.err})
            $display("FAIL timeout_result: got %h/%b expected %h/%b", rsp_data, rsp_error, e.data, e.err);
        else n_pass++;
        ack_rsp();
        n_checks++;
        if (matrix_size !== model_size) $display("FAIL backpressure_no_cmd: got size %b expected %b", matrix_size, model_size);
        else n_pass++;
    endtask

    task automatic test_clear();
        send_cmd(mk_cmd(3'b100, 2'b00, 5'd0, 8'h00, 3'b000, 2'b00));
        model_a = '0; model_b = '0; model_c = '0;
        n_checks++;
        if ({matrix_a, matrix_b, matrix_c, matrix_size} !== {model_a, model_b, model_c, model_size})
            $display("FAIL clear: got nonzero matrix or size %b expected size %b", matrix_size, model_size);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int seen_valid;
        seen_valid = 0;
        send_cmd(mk_cmd(3'b001, 2'b01, 5'd5, 8'h77, 3'b000, 2'b00));
        send_cmd(mk_cmd(3'b011, 2'b00, 5'd0, 8'h00, 3'b111, 2'b00));
        for (int cyc = 1; cyc <= SETTLE + 2; cyc++) @(negedge clk);
        n_checks++;
        if (op_code !== 3'b111) $display("FAIL midrun_busy: got op %b expected 111", op_code);
        else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_a = '0; model_b = '0; model_c = '0; model_size = 2'b00;
        n_checks++;
        if ({op_code, rsp_valid, cmd_ready, matrix_size} !== 7'b0000100 ||
            {matrix_a, matrix_b, matrix_c} !== {model_a, model_b, model_c})
            $display("FAIL midrun_reset: got op=%b valid=%b ready=%b size=%b expected 000 0 1 00",
                     op_code, rsp_valid, cmd_ready, matrix_size);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0) $display("FAIL midrun_no_rsp: got %0d valid cycles expected 0", seen_valid);
        else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_data     = '0;
        rsp_ready    = 1'b0;
        process_Done = 1'b0;
        result_final = '0;
        test_reset();
        test_load();
        test_load_errors();
        test_run_sobel();
        test_back_to_back();
        test_timeout();
        test_clear();
        test_reset_mid_run();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coproc_cmd_sequencer.md
Name: coproc_cmd_sequencer

Overview:
- Command front-end that drives the Sobel coprocessor from the HPS-side bus.
- Accepts 32-bit command words one at a time and assembles matrices A, B and C into 200-bit registers, element by element.
- Sets the matrix size, issues the coprocessor opcode and waits for process_Done, then returns the 8-bit result through a valid/ready response channel.
- Sits between the HPS bridge FIFO and the coprocessor instance; it is the initiator of the coprocessor interface.

Parameters:
- SETTLE_CYCLES, 2, cycles op_code is held stable before process_Done is first sampled (covers the coprocessor's multiply and sqrt combinational depth).
- TIMEOUT_CYCLES, 16, cycles after settle to wait for process_Done before reporting an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command word present
- cmd_ready  out  1  sequencer accepts the command this cycle
- cmd_data  in  32  command word
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  8  result byte
- rsp_error  out  1  error flag qualifying rsp_data
- op_code  out  3  to coprocessor
- matrix_size  out  2  to coprocessor
- matrix_a  out  200  to coprocessor
- matrix_b  out  200  to coprocessor
- matrix_c  out  200  to coprocessor
- process_Done  in  1  from coprocessor
- result_final  in  200  from coprocessor; only bits [7:0] are used

Behaviour:
- Reset is synchronous on rst_n=0. All of the following clear to 0: outputs, the matrix registers, the state (IDLE) and the counters. Reset mid-operation aborts immediately and no response is produced.
- Command fields:
  - [2:0] cmd: 000 NOP, 001 LOAD, 010 SIZE, 011 RUN, 100 CLEAR; any other value is illegal.
  - [4:3] msel: 00 A, 01 B, 10 C, 11 illegal.
  - [9:5] index: row*5+col, valid range 0..24.
  - [17:10] value.
  - [20:18] run opcode.
  - [22:21] size.
- Element i occupies bits [8i+7:8i] of its matrix.
- A command is accepted when cmd_valid && cmd_ready. cmd_ready = 1 only in IDLE.
- IDLE handling of each accepted command:
  - NOP: no effect.
  - LOAD: writes value into the msel matrix at index on the next edge. If index > 24 or msel = 11, there is no write and the sequencer goes to RESP with error = 1 and data = 0.
  - SIZE: matrix_size <= size.
  - CLEAR: all three matrices <= 0.
  - RUN: op_code <= run opcode; go to SETTLE and load cnt = SETTLE_CYCLES-1.
  - Illegal cmd: go to RESP with error = 1.
- SETTLE: cnt decrements each cycle. At 0, go to WAIT and load cnt = TIMEOUT_CYCLES-1.
- WAIT: sample process_Done.
  - If 1: latch result_final[7:0] into rsp_data, error = 0, go to RESP.
  - Else if cnt = 0: rsp_data = 0, error = 1, go to RESP.
  - Else decrement cnt.
  - Opcodes the coprocessor does not implement therefore time out with an error.
- op_code returns to 0 on leaving WAIT.
- RESP: rsp_valid = 1, with rsp_data and rsp_error held stable until rsp_ready. The transfer happens on the cycle with rsp_valid && rsp_ready; return to IDLE on the next edge.
- Back-pressure is unbounded; no new command is accepted while in RESP.
- Matrices and matrix_size persist across RUNs until CLEAR, reset or an overwrite.
- Latency: RUN accepted at cycle t gives rsp_valid at t + SETTLE_CYCLES + k + 1, where k is the WAIT cycles used (minimum 1).
- Only LOAD, SIZE, CLEAR and RUN change registers, and only in IDLE.

Decomposition:
- Shared package coproc_pkg holds:
  - the cmd encodings and the command field bit positions;
  - the coprocessor opcode constants (OP_SOBEL = 3'b111);
  - the size encodings (00 2x2, 01 3x3, 10 4x4, 11 5x5);
  - ELEM_W = 8 and N_ELEM = 25.
- One sub-module, coproc_matrix_bank: the three 200-bit registers with the write-enable decode, index range check and clear.

Test Plan:
- Reset with rst_n=0 held 2 cycles: all outputs 0, cmd_ready=1, rsp_valid=0.
- LOAD A, index 24, value 0xAB: matrix_a[199:192]=0xAB and all other bits unchanged. Then LOAD B, index 0, value 0x01: matrix_b[7:0]=0x01.
- LOAD index 25, then LOAD with msel=11: each gives one response with rsp_error=1, rsp_data=0x00, and no matrix bit changes.
- SIZE 01, then RUN opcode 111 with a stub that asserts process_Done on the 3rd WAIT cycle with result_final[7:0]=0x2A:
  - op_code=111 through SETTLE and WAIT;
  - rsp_data=0x2A, rsp_error=0;
  - rsp_valid rises exactly SETTLE_CYCLES+3+1 cycles after acceptance.
- RUN opcode 000 (process_Done never asserted): after SETTLE_CYCLES+TIMEOUT_CYCLES cycles rsp_valid=1 with rsp_error=1 and op_code back to 0. With rsp_ready held low for 10 cycles the response stays stable and cmd_ready stays 0.
- Pull rst_n low during WAIT: on the next edge state is IDLE, op_code=0, matrices are 0 and no response is ever emitted.
